// File: rtl/cla_sub_seq_if.sv
// cla_sub_seq_if: start/busy/done handshake and operand/result bus for cla_sub_seq.
// ovf_o exists only when CLA_SUB_OVF_EN is defined.
interface cla_sub_seq_if #(parameter int N = 8);
    logic         start_i;
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic         busy_o;
    logic         done_o;
    logic [N:0]   diff_o;
`ifdef CLA_SUB_OVF_EN
    logic         ovf_o;
    modport master (output start_i, a_i, b_i, input busy_o, done_o, diff_o, ovf_o);
    modport slave  (input start_i, a_i, b_i, output busy_o, done_o, diff_o, ovf_o);
`else
    modport master (output start_i, a_i, b_i, input busy_o, done_o, diff_o);
    modport slave  (input start_i, a_i, b_i, output busy_o, done_o, diff_o);
`endif
endinterface

// File: rtl/cla_sub_seq.sv
// cla_sub_seq: multi-cycle A-B, one G-bit lookahead group per clock, LSB group first.
// Optional signed-overflow output enabled by CLA_SUB_OVF_EN.
module cla_sub_seq #(
    parameter int N = 8,
    parameter int G = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    cla_sub_seq_if.slave  bus
);
    localparam int NG = N / G;
    localparam int IW = NG > 1 ? $clog2(NG) : 1;

    if (N % G != 0) begin : g_bad_width
        $error("cla_sub_seq: N must be a multiple of G");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic            c_q, c_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [N:0]      diff_q, diff_d;
    logic [G-1:0]    ga, gb, p, g, s;
    logic [G:0]      c;
    logic            last;

    function automatic logic [G-1:0] lo(input int k);
        lo = '0;
        for (int x = 0; x < G; x++) lo[x] = x < k;
    endfunction

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;

    always_comb
        state_d = state_q == IDLE ? (bus.start_i ? RUN : IDLE) :
                  state_q == RUN  ? (last ? DONE : RUN) : IDLE;

    always_comb begin
        bus.busy_o = state_q == RUN;
        bus.done_o = state_q == DONE;
    end

    // Each carry is a flat sum of generate terms gated by propagate products.
    always_comb begin
        ga = a_q[idx_q*G +: G];
        gb = b_q[idx_q*G +: G];
        p = ga ^ gb;
        g = ga & gb;
        c = '0;
        c[0] = c_q;
        for (int i = 0; i < G; i++) begin
            c[i+1] = c_q & (&(p | ~lo(i + 1)));
            for (int j = 0; j <= i; j++)
                c[i+1] = c[i+1] | (g[j] & (&(p | ~(lo(i + 1) & ~lo(j + 1)))));
        end
        s = p ^ c[G-1:0];
        last = idx_q == IW'(NG - 1);
    end

`ifdef CLA_SUB_OVF_EN
    logic ovf_q, ovf_d;
    assign bus.ovf_o = ovf_q;
`endif

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        idx_d = idx_q;
        res_d = res_q;
        diff_d = diff_q;
`ifdef CLA_SUB_OVF_EN
        ovf_d = ovf_q;
`endif
        if (state_q == IDLE && bus.start_i) begin
            a_d = bus.a_i;
            b_d = ~bus.b_i;
            c_d = 1'b1;
            idx_d = '0;
        end else if (state_q == RUN) begin
            res_d[idx_q*G +: G] = s;
            c_d = c[G];
            idx_d = idx_q + IW'(1);
            if (last) begin
                diff_d = {~c[G], res_d};
`ifdef CLA_SUB_OVF_EN
                // b_q holds ~B, so equal MSBs here mean A and B had opposite signs.
                ovf_d = (a_q[N-1] == b_q[N-1]) && (res_d[N-1] != a_q[N-1]);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= 1'b0;
            idx_q <= '0;
            res_q <= '0;
            diff_q <= '0;
`ifdef CLA_SUB_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            idx_q <= idx_d;
            res_q <= res_d;
            diff_q <= diff_d;
`ifdef CLA_SUB_OVF_EN
            ovf_q <= ovf_d;
`endif
        end

    assign bus.diff_o = diff_q;
endmodule

// File: tb/tb_cla_sub_seq.sv
// tb_cla_sub_seq: directed vector table plus hand-written reset/back-to-back sequences.
// Overflow expectations are compared only when CLA_SUB_OVF_EN is defined.
module tb_cla_sub_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    logic [8:0] last_d = '0;

    always #5 clk = ~clk;

    cla_sub_seq_if #(.N(8)) bus ();
    cla_sub_seq #(.N(8), .G(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] d;
        logic       o;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, output logic [8:0] d, output int lat);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i = a;
        bus.b_i = b;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.a_i = ~a;
        bus.b_i = 8'h5A;
        chk("busy_after_accept", {31'b0, bus.busy_o}, 1);
        chk("diff_held_in_run", {23'b0, bus.diff_o}, {23'b0, last_d});
        lat = 0;
        while (!bus.done_o && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        d = bus.diff_o;
    endtask

    initial begin
        logic [8:0] d;
        int lat;
        tbl[0]  = '{8'h33, 8'h1E, 9'h015, 1'b0};
        tbl[1]  = '{8'h1E, 8'h33, 9'h1EB, 1'b0};
        tbl[2]  = '{8'h00, 8'h01, 9'h1FF, 1'b0};
        tbl[3]  = '{8'h55, 8'h55, 9'h000, 1'b0};
        tbl[4]  = '{8'hFF, 8'h01, 9'h0FE, 1'b0};
        tbl[5]  = '{8'h10, 8'h20, 9'h1F0, 1'b0};
        tbl[6]  = '{8'h80, 8'h01, 9'h07F, 1'b1};
        tbl[7]  = '{8'h05, 8'h03, 9'h002, 1'b0};
        tbl[8]  = '{8'h55, 8'h32, 9'h023, 1'b0};
        tbl[9]  = '{8'hFF, 8'hFF, 9'h000, 1'b0};
        tbl[10] = '{8'h00, 8'hFF, 9'h101, 1'b0};
        tbl[11] = '{8'h7F, 8'h80, 9'h1FF, 1'b1};
        tbl[12] = '{8'h10, 8'h01, 9'h00F, 1'b0};

        bus.start_i = 1'b1;
        bus.a_i = 8'h33;
        bus.b_i = 8'h1E;
        for (int t = 0; t < 3; t++) begin
            #4;
            chk("reset_busy", {31'b0, bus.busy_o}, 0);
            chk("reset_done", {31'b0, bus.done_o}, 0);
            chk("reset_diff", {23'b0, bus.diff_o}, 0);
        end
        #5;
        bus.start_i = 1'b0;
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("idle_no_done", {31'b0, bus.done_o}, 0);
            chk("idle_no_busy", {31'b0, bus.busy_o}, 0);
        end

        for (int i = 0; i < 13; i++) begin
            op(tbl[i].a, tbl[i].b, d, lat);
            chk($sformatf("latency[%0d]", i), lat, 2);
            chk($sformatf("diff[%0d]", i), {23'b0, d}, {23'b0, tbl[i].d});
`ifdef CLA_SUB_OVF_EN
            chk($sformatf("ovf[%0d]", i), {31'b0, bus.ovf_o}, {31'b0, tbl[i].o});
`endif
            last_d = tbl[i].d;
        end

        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i = 8'h55;
        bus.b_i = 8'h32;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i % 4 == 0) begin
                bus.a_i = 8'h00;
                bus.b_i = 8'hFF;
            end
            if (i % 4 == 2) begin
                chk("held_done_pulse", {31'b0, bus.done_o}, 1);
                chk("held_diff", {23'b0, bus.diff_o}, 9'h023);
                bus.a_i = 8'h55;
                bus.b_i = 8'h32;
            end else chk("held_no_done", {31'b0, bus.done_o}, 0);
        end
        bus.start_i = 1'b0;
        repeat (4) @(negedge clk);
        last_d = 9'h023;

        bus.start_i = 1'b1;
        bus.a_i = 8'hFF;
        bus.b_i = 8'h01;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("abort_busy_before", {31'b0, bus.busy_o}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, bus.busy_o}, 0);
        chk("abort_diff", {23'b0, bus.diff_o}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_d = '0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, bus.done_o}, 0);
            chk("abort_diff_zero", {23'b0, bus.diff_o}, 0);
        end
        op(8'h10, 8'h20, d, lat);
        chk("post_abort_latency", lat, 2);
        chk("post_abort_diff", {23'b0, d}, 9'h1F0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cla_sub_seq.md
Name: cla_sub_seq

Overview:
- Multi-cycle unsigned subtractor computing A − B, the inverse of the CLA adder.
- Resolves one G-bit carry-lookahead group per clock, starting from the LSB group; the group carry-out is registered between groups.
- start/busy/done handshake. Result is N+1 bits: the MSB is the borrow, the same width convention as the adder's sum.
- Used wherever difference or compare results are needed without a full-width single-cycle lookahead tree.

Parameters:
- N, 8, operand width in bits.
- G, 4, lookahead group width; N must be a multiple of G (elaboration error otherwise).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  N  minuend; captured on start acceptance.
- B  input  N  subtrahend; captured on start acceptance.
- busy  output  1  high while groups are being computed.
- done  output  1  one-cycle pulse when diff is updated.
- diff  output  N+1  diff[N-1:0] = (A − B) mod 2^N; diff[N] = borrow (1 iff A < B unsigned).

Behaviour:
- Reset (reset = 0, asynchronous): state=IDLE, busy=0, done=0, diff=0, working registers=0, group index=0, carry=0. While reset is low, start is ignored.
- States:
  - IDLE: start=1 at an edge → RUN. At that edge: latch A and ~B into working registers, carry=1, index=0, busy=1.
  - RUN: each edge computes group index over bits [index*G +: G]:
    - p = a^b', g = a&b'.
    - In-group carries by lookahead: c[i+1] = g[i] | p[i]&c[i], flattened, not rippled.
    - Write sum bits into the working result; carry ← group carry-out; index++.
    - On the edge computing group N/G−1: diff[N-1:0] ← final result, diff[N] ← ~carry_out, busy=0, done=1, state → DONE.
  - DONE: next edge → IDLE, done=0.
- Latency: start accepted at edge 0 → done high after edge N/G (2 edges for the default) and low after edge N/G+1.
- Minimum start-to-start period with start held high: N/G+2 cycles.
- diff keeps its previous value through RUN; it changes only on the done edge. diff is held until the next done.
- start in RUN or DONE is ignored; there is no queueing.
- A and B may change freely after acceptance; they do not affect an operation in flight.
- Reset mid-RUN aborts the operation: all outputs go to 0 and no done pulse is produced.

Optional Feature:
- Macro CLA_SUB_OVF_EN.
- When defined:
  - Extra output ovf (1 bit), reset 0, updated only on the done edge.
  - ovf = (A[N-1] != B[N-1]) && (result[N-1] != A[N-1]), using the latched operands (two's-complement signed overflow).
- When undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 15 time units with start=1 → busy=0, done=0, diff=0 throughout; no done pulse after release until start is sampled in IDLE.
- A=8'h33, B=8'h1E, start for one cycle → busy high for 2 cycles; done pulse after edge 2; diff=9'h015.
- A=8'h1E, B=8'h33 → diff=9'h1EB (borrow=1). Then A=8'h00, B=8'h01 → diff=9'h1FF. Then A=8'h55, B=8'h55 → diff=9'h000.
- start held high with A=8'h55, B=8'h32 → done every 4 cycles, diff=9'h023 each time. Changing A and B during RUN does not alter the in-flight result.
- Assert reset=0 during the first RUN cycle of A=8'hFF, B=8'h01 → diff=0 and no done. After release, new start with A=8'h10, B=8'h20 → diff=9'h1F0.
- CLA_SUB_OVF_EN defined:
  - A=8'h80, B=8'h01 → diff=9'h07F, ovf=1.
  - A=8'h05, B=8'h03 → diff=9'h002, ovf=0.
